// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and shifts each byte out as an 8N1/8N2 UART frame.
// The FIFO output is registered, so a byte is popped in FETCH and captured one cycle later in LOAD.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    sreg, sreg_n;
  logic          tx_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sreg    <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      sreg    <= sreg_n;
      tx      <= tx_n;
    end
  end

  // tx_n is the line level for the state being entered, so the pin register stays aligned with state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    sreg_n    = sreg;
    tx_n      = 1'b1;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (enable && !fifo_empty) state_n = FETCH;
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        sreg_n  = fifo_data;
        state_n = START;
        tx_n    = 1'b0;
      end
      START: begin
        tx_n  = 1'b0;
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          state_n = DATA;
          tx_n    = sreg[0];
        end
      end
      DATA: begin
        tx_n  = sreg[0];
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = STOP;
            tx_n      = 1'b1;
          end else begin
            // Next bit sits one position up until the shift lands.
            bit_idx_n = bit_idx + 1'b1;
            sreg_n    = {1'b0, sreg[7:1]};
            tx_n      = sreg[1];
          end
        end
      end
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            state_n   = IDLE;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign fifo_read  = (state == FETCH);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && bit_end && (bit_idx == STOP_LAST);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: directed bytes are queued as expectations, a per-instance monitor decodes tx frames.
// Instance 0 runs 8N1 and instance 1 runs 8N2, both at 4 clocks per bit.
module tb_fifo_uart_tx;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] en, fempty, rd_w, tx_w, busy_w, fd_w, abort_next;
  logic [1:0][7:0] fdata;
  logic [7:0] bytes [2][64];
  int wr_ptr[2], rd_ptr[2], fd_cnt[2], rd_cyc[2], spur[2];
  int cyc = 0;
  logic [7:0] exp0[$], exp1[$];
  int st0[$], st1[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign fempty[0] = (rd_ptr[0] == wr_ptr[0]);
  assign fempty[1] = (rd_ptr[1] == wr_ptr[1]);

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .enable(en[0]), .fifo_empty(fempty[0]), .fifo_data(fdata[0]),
    .fifo_read(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .enable(en[1]), .fifo_empty(fempty[1]), .fifo_data(fdata[1]),
    .fifo_read(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

  // FIFO model: registered data_out valid the cycle after read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < 2; u++) begin
      if (rd_w[u]) begin
        if (rd_ptr[u] == wr_ptr[u]) spur[u] <= spur[u] + 1;
        fdata[u]  <= bytes[u][rd_ptr[u][5:0]];
        rd_ptr[u] <= rd_ptr[u] + 1;
      end
      if (fd_w[u]) fd_cnt[u] <= fd_cnt[u] + 1;
    end
  end

  always @(negedge clk)
    for (int u = 0; u < 2; u++)
      if (rd_w[u]) rd_cyc[u] <= cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int u, input logic [7:0] b, input bit ex);
    bytes[u][wr_ptr[u][5:0]] = b;
    wr_ptr[u] = wr_ptr[u] + 1;
    if (ex) begin
      if (u == 0) exp0.push_back(b);
      else exp1.push_back(b);
    end
  endtask

  task automatic wait_fd(input int u, input int n, input int bound);
    for (int i = 0; i < bound && fd_cnt[u] < n; i++) tick;
    chk("frame_done_wait", int'(fd_cnt[u] >= n), 1);
  endtask

  function automatic logic lvl(input logic [7:0] e, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return e[k-1];
    return 1'b1;
  endfunction

  task automatic mon(input int u);
    logic prev = 1'b1;
    logic [7:0] e, got;
    logic ab, aborted;
    int s, len, bad, fdbad;
    len = (u == 0) ? 10 * C : 11 * C;
    forever begin
      @(negedge clk);
      if (prev && !tx_w[u] && !reset) begin
        s = cyc;
        if (u == 0) st0.push_back(s);
        else st1.push_back(s);
        chk("read_to_start", s - rd_cyc[u], 2);
        ab = abort_next[u];
        e = 8'h00;
        if (!ab) begin
          if (u == 0 && exp0.size() > 0) e = exp0.pop_front();
          else if (u == 1 && exp1.size() > 0) e = exp1.pop_front();
          else chk("unexpected_frame", 1, 0);
        end
        bad = 0; fdbad = 0; got = '0; aborted = 1'b0;
        for (int i = 0; i < len; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (tx_w[u] !== lvl(e, i / C) || busy_w[u] !== 1'b1) bad++;
          if (fd_w[u] !== (i == len - 1)) fdbad++;
          if (i % C == C / 2 && i / C >= 1 && i / C <= 8) got[i/C-1] = tx_w[u];
        end
        if (aborted) begin
          chk("reset_expected", int'(ab), 1);
          @(negedge clk);
          chk("reset_tx_busy", int'({tx_w[u], busy_w[u]}), 2);
        end else begin
          chk("abort_missing", int'(ab), 0);
          chk("frame_wave", bad, 0);
          chk("frame_done_pos", fdbad, 0);
          chk("payload", int'(got), int'(e));
        end
      end
      prev = tx_w[u];
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 2'b11;
    abort_next = 2'b00;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", int'({tx_w[0], busy_w[0], rd_w[0], fd_w[0]}), 8);
    end

    // single byte
    tick;
    push(0, 8'hA5, 1);
    wait_fd(0, 1, 200);
    chk("single_read_count", rd_ptr[0], 1);

    // back-to-back 0x00, 0xFF
    push(0, 8'h00, 1);
    push(0, 8'hFF, 1);
    wait_fd(0, 3, 300);
    chk("b2b_period", (st0.size() >= 3) ? st0[2] - st0[1] : -1, 43);

    // enable low holds off reads
    en[0] = 1'b0;
    push(0, 8'h3C, 1);
    push(0, 8'h81, 0);
    repeat (100) tick;
    chk("disabled_no_read", rd_ptr[0], 3);

    // drop enable mid-DATA
    en[0] = 1'b1;
    for (int i = 0; i < 50 && st0.size() < 4; i++) tick;
    chk("start_seen", int'(st0.size()), 4);
    repeat (10) tick;
    en[0] = 1'b0;
    wait_fd(0, 4, 200);
    repeat (100) tick;
    chk("drop_enable_reads", rd_ptr[0], 4);

    // reset during data bit 3; the popped 0x81 is lost
    abort_next[0] = 1'b1;
    en[0] = 1'b1;
    for (int i = 0; i < 50 && st0.size() < 5; i++) tick;
    chk("start_seen", int'(st0.size()), 5);
    repeat (16) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    abort_next[0] = 1'b0;
    push(0, 8'h5A, 1);
    wait_fd(0, 5, 200);
    chk("post_reset_reads", rd_ptr[0], 6);

    // two stop bits
    push(1, 8'h55, 1);
    push(1, 8'h55, 1);
    wait_fd(1, 2, 300);
    chk("sb2_period", (st1.size() >= 2) ? st1[1] - st1[0] : -1, 47);

    repeat (5) tick;
    chk("spurious_read0", spur[0], 0);
    chk("spurious_read1", spur[1], 0);
    chk("frame_done_total0", fd_cnt[0], 5);
    chk("frame_done_total1", fd_cnt[1], 2);
    chk("exp_left0", int'(exp0.size()), 0);
    chk("exp_left1", int'(exp1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
